// File: rtl/mcpu_seq_ctrl_if.sv
// Sequencer <-> datapath bundle: IR fields, ALU zero, memory readies in; enables/selects out.
// slave = sequencer side, master = datapath side.
interface mcpu_seq_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       ir_wen;
  logic       pc_wen;
  logic [1:0] pc_src;
  logic       alusrc;
  logic [1:0] aluop;
  logic       signext;
  logic       regdst;
  logic       memtoreg;
  logic       link;
  logic       reg_wen;
  logic       dmem_ren;
  logic       dmem_wen;
  logic [3:0] state;
  logic       illegal;

  modport slave (
    input  opcode, funct, zero, imem_ready, dmem_ready,
    output imem_req, ir_wen, pc_wen, pc_src, alusrc, aluop, signext, regdst,
           memtoreg, link, reg_wen, dmem_ren, dmem_wen, state, illegal
  );

  modport master (
    output opcode, funct, zero, imem_ready, dmem_ready,
    input  imem_req, ir_wen, pc_wen, pc_src, alusrc, aluop, signext, regdst,
           memtoreg, link, reg_wen, dmem_ren, dmem_wen, state, illegal
  );
endinterface

// File: rtl/mcpu_seq_ctrl.sv
// Multi-cycle MIPS sequencer, Moore FSM; MCPU_PERF_CNT_EN adds cycle/instret counters.
// Zero-wait latency: R/I 4, lw 5, sw 4, branch 3, jump 3; stalls in FETCH/MEM_RD/MEM_WR on ready low.
module mcpu_seq_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  mcpu_seq_ctrl_if.slave   bus
`ifdef MCPU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_t     r_state;
  state_t     w_next;
  logic       w_rtype;
  logic       w_jr;
  logic       w_jal;
  logic       w_imem_req;
  logic       w_ir_wen;
  logic       w_pc_wen;
  logic [1:0] w_pc_src;
  logic       w_alusrc;
  logic [1:0] w_aluop;
  logic       w_signext;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_link;
  logic       w_reg_wen;
  logic       w_dmem_ren;
  logic       w_dmem_wen;
  logic       w_illegal;

  assign w_rtype = (bus.opcode == 6'b000000);
  assign w_jr    = w_rtype && (bus.funct == 6'b001000);
  assign w_jal   = (bus.opcode == 6'b000011);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_wen   = 1'b0;
    w_pc_wen   = 1'b0;
    w_pc_src   = 2'b00;
    w_alusrc   = 1'b0;
    w_aluop    = 2'b00;
    w_signext  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_link     = 1'b0;
    w_reg_wen  = 1'b0;
    w_dmem_ren = 1'b0;
    w_dmem_wen = 1'b0;
    w_illegal  = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_wen = 1'b1;
          w_pc_wen = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        casez (bus.opcode)
          6'b000000:            w_next = w_jr ? S_JUMP : S_EXEC_R;
          6'b0010??, 6'b0011??: w_next = S_EXEC_I;
          6'b100011, 6'b101011: w_next = S_MEM_ADDR;
          6'b00010?:            w_next = S_BRANCH;
          6'b00001?:            w_next = S_JUMP;
          default:              w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        w_aluop = 2'b10;
        w_next  = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_alusrc  = 1'b1;
        w_aluop   = 2'b11;
        w_signext = (bus.opcode[5:2] != 4'b0011);
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        // IR is still stable, so the EXEC-state ALU controls are re-derived from it
        if (w_rtype) begin
          w_aluop  = 2'b10;
          w_regdst = 1'b1;
        end else begin
          w_alusrc  = 1'b1;
          w_aluop   = 2'b11;
          w_signext = (bus.opcode[5:2] != 4'b0011);
        end
        w_reg_wen = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_alusrc  = 1'b1;
        w_signext = 1'b1;
        w_next    = bus.opcode[3] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_alusrc   = 1'b1;
        w_signext  = 1'b1;
        w_dmem_ren = 1'b1;
        if (bus.dmem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_wen  = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        w_alusrc   = 1'b1;
        w_signext  = 1'b1;
        w_dmem_wen = 1'b1;
        if (bus.dmem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_aluop  = 2'b01;
        w_pc_src = 2'b01;
        w_pc_wen = bus.zero ^ bus.opcode[0];
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        w_pc_wen  = 1'b1;
        w_pc_src  = w_jr ? 2'b11 : 2'b10;
        w_link    = w_jal;
        w_reg_wen = w_jal;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        w_illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks every output in the same cycle so an aborted store never strobes
  assign bus.imem_req = w_imem_req & ~rst;
  assign bus.ir_wen   = w_ir_wen   & ~rst;
  assign bus.pc_wen   = w_pc_wen   & ~rst;
  assign bus.pc_src   = rst ? 2'b00 : w_pc_src;
  assign bus.alusrc   = w_alusrc   & ~rst;
  assign bus.aluop    = rst ? 2'b00 : w_aluop;
  assign bus.signext  = w_signext  & ~rst;
  assign bus.regdst   = w_regdst   & ~rst;
  assign bus.memtoreg = w_memtoreg & ~rst;
  assign bus.link     = w_link     & ~rst;
  assign bus.reg_wen  = w_reg_wen  & ~rst;
  assign bus.dmem_ren = w_dmem_ren & ~rst;
  assign bus.dmem_wen = w_dmem_wen & ~rst;
  assign bus.illegal  = w_illegal  & ~rst;
  assign bus.state    = rst ? 4'd0 : r_state;

`ifdef MCPU_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic             w_retire;

  // DECODE->FETCH only happens for an illegal op retired as a NOP
  always_comb begin
    w_retire = 1'b0;
    if (w_next == S_FETCH) begin
      case (r_state)
        S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_DECODE: w_retire = 1'b1;
        default: w_retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_retire)          r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = rst ? '0 : r_cycle_cnt;
  assign instret_cnt = rst ? '0 : r_instret_cnt;
`endif

endmodule

// File: doc/mcpu_seq_ctrl.md
Name: mcpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath: PC, instruction memory, register file, extender, ALU control, ALU and data memory.
- Replaces the single-cycle CTRL decode with a Moore-style FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Generates per-state enables and mux selects, and waits on memory-ready handshakes.
- Sits beside the datapath; reads opcode/funct from the instruction register and zero from the ALU.

Parameters:
- HALT_ON_ILLEGAL, 1, 1: an illegal opcode enters HALT. 0: an illegal opcode is retired as a NOP (DECODE -> FETCH).
- CNT_W, 32, width of the performance counters; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data read/write completes this cycle
- imem_req  out  1  fetch request
- ir_wen  out  1  load IR
- pc_wen  out  1  load PC
- pc_src  out  2  00 pc+4, 01 branch target, 10 jump target, 11 rs (jr)
- alusrc  out  1  0 rt, 1 extended immediate
- aluop  out  2  00 add, 01 sub, 10 funct, 11 I-type opcode
- signext  out  1  1 sign-extend, 0 zero-extend
- regdst  out  1  1 rd, 0 rt
- memtoreg  out  1  register write data from dmem
- link  out  1  write pc+4 to r31
- reg_wen  out  1  register file write
- dmem_ren  out  1  data read strobe
- dmem_wen  out  1  data write strobe
- state  out  4  current state, for debug
- illegal  out  1  held high in HALT

Behaviour:
- Single 4-bit state register. Outputs are combinational from state, opcode, funct and zero.
- rst=1 at a clock edge sets state to FETCH(0). While rst=1 every output is 0.
- Reset mid-operation aborts the instruction. No partial write occurs after the reset edge.
- Default value of every output is 0; only the values listed below are asserted.
- FETCH(0): imem_req=1. If imem_ready=1: ir_wen=1, pc_wen=1, pc_src=00, go to DECODE. Otherwise stay.
- DECODE(1): classify opcode.
  - 000000 with funct=001000 (jr) -> JUMP; any other 000000 -> EXEC_R.
  - 0010xx and 0011xx -> EXEC_I.
  - 100011 (lw) and 101011 (sw) -> MEM_ADDR.
  - 000100 (beq) and 000101 (bne) -> BRANCH.
  - 000010 (j) and 000011 (jal) -> JUMP.
  - Anything else -> HALT, or FETCH if HALT_ON_ILLEGAL=0.
- EXEC_R(2): alusrc=0, aluop=10 -> ALU_WB.
- EXEC_I(3): alusrc=1, aluop=11, signext = (opcode[5:2]!=4'b0011) -> ALU_WB.
- ALU_WB(4): ALU controls held as in the EXEC state; reg_wen=1, regdst=1 for R-type else 0 -> FETCH.
- MEM_ADDR(5): alusrc=1, aluop=00, signext=1 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD(6): address controls held, dmem_ren=1. Stay until dmem_ready=1, then -> MEM_WB.
- MEM_WB(7): reg_wen=1, memtoreg=1, regdst=0 -> FETCH.
- MEM_WR(8): address controls held, dmem_wen=1. Stay until dmem_ready=1, then -> FETCH.
- BRANCH(9): alusrc=0, aluop=01, pc_src=01, pc_wen = zero XOR opcode[0] -> FETCH.
- JUMP(10): pc_wen=1, pc_src=11 for jr, else 10. For jal: link=1, reg_wen=1 -> FETCH.
- HALT(11): illegal=1, all enables 0. Exit only via rst.
- Unused encodings 12-15 -> FETCH next cycle, no enables asserted.
- Latency with zero-wait memories (cycles): R/I-type 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3. Each memory wait cycle adds 1.
- dmem_ready or imem_ready outside their waiting states is ignored.

Optional Feature:
- Macro MCPU_PERF_CNT_EN.
- When defined, two extra outputs exist:
  - cycle_cnt [CNT_W]: increments every non-reset cycle except in HALT.
  - instret_cnt [CNT_W]: increments on each transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP; also from DECODE when an illegal op is retired as a NOP.
- Both counters clear on rst and wrap modulo 2^CNT_W.
- When not defined, neither port nor either counter register exists.

Test Plan:
- add (op 000000, funct 100000), readies tied 1 -> state 0,1,2,4,0; reg_wen=1 and regdst=1 only in cycle 4; pc_wen=1 only in cycle 1.
- lw (100011) with dmem_ready low 3 cycles -> MEM_RD held 4 cycles with dmem_ren=1; then MEM_WB with reg_wen=1, memtoreg=1; 8 cycles total.
- beq zero=1 then bne zero=1 -> pc_wen=1, pc_src=01 for beq; pc_wen=0 for bne; both return to FETCH after 3 cycles.
- jal (000011) then jr (000000/001000) -> JUMP: jal gives link=1, reg_wen=1, pc_src=10; jr gives pc_src=11, reg_wen=0.
- Opcode 111111 -> HALT, illegal=1, stays 10 cycles; rst pulse -> FETCH with all outputs 0 during rst. With HALT_ON_ILLEGAL=0 -> DECODE to FETCH, illegal=0.
- sw, rst asserted in MEM_WR with dmem_ready=0 -> dmem_wen=0 from that cycle, state=0 after the edge. With MCPU_PERF_CNT_EN, both counters read 0 after rst.
